// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, memory depth, NOP encoding,
// the opcode field used by fetch and decode, and the response-slot state type.
package cpu_pkg;

    localparam int INSTR_W    = 32;
    localparam int IMEM_DEPTH = 4096;

    typedef logic [31:0] word_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;

    // Primary opcode field, bits [31:26] of every instruction word.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    function automatic logic [5:0] opcode_of(input word_t instr);
        return instr[31:26];
    endfunction

    // Full-width range check so high address bits never alias into memory.
    function automatic logic addr_in_range(input word_t addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port-write, synchronous-read instruction RAM. Contents are never
// reset so a program survives a CPU reset.
module imem_ram
    import cpu_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = INSTR_W
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data only moves on a read enable, so it holds under backpressure.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_server.sv
// Instruction-memory responder: one fetch per cycle into a single registered
// response slot, plus a program-load write port that takes priority over fetch.
module imem_server
    import cpu_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = INSTR_W
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          fetch_req_valid,
    output logic          fetch_req_ready,
    input  logic [31:0]   fetch_addr,

    output logic          fetch_rsp_valid,
    input  logic          fetch_rsp_ready,
    output logic [DW-1:0] fetch_rsp_instr,
    output logic          fetch_rsp_err,

    input  logic          load_valid,
    output logic          load_ready,
    input  logic [31:0]   load_addr,
    input  logic [DW-1:0] load_data,

    output logic [15:0]   fetch_count,
    output logic [15:0]   load_count,
    output slot_state_t   dbg_state
);

    // Handshake rule for every channel here: a transfer happens on a rising
    // edge where valid && ready; valid never waits on ready, and the sender
    // holds its payload stable until the transfer completes.

    slot_state_t   state;
    logic          hit_q;
    logic          err_q;
    logic [DW-1:0] ram_rdata;

    logic fetch_accept;
    logic rsp_consume;
    logic load_accept;
    logic fetch_in_range;
    logic load_in_range;

    assign fetch_rsp_valid = (state == SLOT_FULL);
    assign fetch_req_ready = !load_valid && (!fetch_rsp_valid || fetch_rsp_ready);
    assign load_ready      = !fetch_rsp_valid;

    assign fetch_accept   = fetch_req_valid && fetch_req_ready;
    assign rsp_consume    = fetch_rsp_valid && fetch_rsp_ready;
    assign load_accept    = load_valid && load_ready;
    assign fetch_in_range = addr_in_range(fetch_addr, DEPTH);
    assign load_in_range  = addr_in_range(load_addr, DEPTH);

    imem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_ram (
        .clk   (clk),
        .we    (load_accept && load_in_range),
        .waddr (load_addr[AW-1:0]),
        .wdata (load_data),
        .re    (fetch_accept && fetch_in_range),
        .raddr (fetch_addr[AW-1:0]),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SLOT_EMPTY;
        end else begin
            case (state)
                SLOT_EMPTY: if (fetch_accept) state <= SLOT_FULL;
                SLOT_FULL:  if (rsp_consume && !fetch_accept) state <= SLOT_EMPTY;
                default:    state <= SLOT_EMPTY;
            endcase
        end
    end

    // hit_q selects RAM data; out-of-range and post-reset both show a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= 1'b0;
            err_q <= 1'b0;
        end else if (fetch_accept) begin
            hit_q <= fetch_in_range;
            err_q <= !fetch_in_range;
        end
    end

    assign fetch_rsp_instr = hit_q ? ram_rdata : NOP_INSTR;
    assign fetch_rsp_err   = err_q;
    assign dbg_state       = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 16'h0000;
            load_count  <= 16'h0000;
        end else begin
            if (fetch_accept && fetch_count != 16'hFFFF) begin
                fetch_count <= fetch_count + 16'h0001;
            end
            if (load_accept && load_in_range && load_count != 16'hFFFF) begin
                load_count <= load_count + 16'h0001;
            end
        end
    end

endmodule

// File: doc/imem_server.md
# imem_server

Instruction-memory responder serving the CPU fetch stage. Accepts one word-address fetch request per cycle through a valid/ready handshake and returns the addressed 32-bit instruction one cycle later through a registered response channel. A separate load port lets the bench or boot logic write program words into the same memory. Sits between the fetch stage, which issues `programCounter`, and the decode stage, which consumes `instruction`.

## Interface
- `DEPTH`, 4096: memory size in 32-bit words; power of two.
- `AW`, $clog2(DEPTH): internal index width.
- `DW`, 32: instruction width; fixed at 32.

- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `fetch_req_valid` in 1: fetch request present.
- `fetch_req_ready` out 1: request accepted when valid && ready.
- `fetch_addr` in 32: word address (program counter value).
- `fetch_rsp_valid` out 1: response present.
- `fetch_rsp_ready` in 1: consumer takes response when valid && ready.
- `fetch_rsp_instr` out 32: instruction word.
- `fetch_rsp_err` out 1: request address was out of range.
- `load_valid` in 1: program-load write present.
- `load_ready` out 1: write accepted when valid && ready.
- `load_addr` in 32: word address to write.
- `load_data` in 32: word to write.
- `fetch_count` out 16: accepted fetches, saturating at 16'hFFFF.
- `load_count` out 16: accepted in-range loads, saturating at 16'hFFFF.

## Operation
- **Response slot:** one registered slot with two states.
  - EMPTY → FULL on fetch accept.
  - FULL → EMPTY on consume without a new accept.
  - FULL stays FULL on consume plus a new accept in the same cycle. This gives back-to-back throughput of 1 fetch/cycle.
- **Ready rules:**
  - `fetch_req_ready` = !load_valid && (!fetch_rsp_valid || fetch_rsp_ready).
  - `load_ready` = !fetch_rsp_valid.
- **Priority:** load wins over fetch in the same cycle. A fetch request stays pending; the requester must hold `fetch_addr` stable while valid.
- **In-range fetch:** `fetch_addr` < DEPTH. Response instr = mem[fetch_addr[AW-1:0]], err = 0.
- **Out-of-range fetch:** `fetch_addr` ≥ DEPTH, compared over the full 32 bits.
  - instr = 32'h0000_0000 (NOP), err = 1.
  - The fetch is still counted.
- **Load writes:**
  - In range: write mem at the accept edge and increment `load_count`.
  - Out of range: the handshake completes but the write and the count are dropped silently.
- **Read-after-write:** a fetch accepted the cycle after a load to the same address returns the new data.
- **Response stability:** `fetch_rsp_instr` and `fetch_rsp_err` stay stable while valid && !ready.
- **Memory contents:** not reset. Reading an unwritten word returns X; benches preload before fetching.

## Timing
- **Fetch latency:** request accepted at edge N → `fetch_rsp_valid` high after edge N, i.e. visible in cycle N+1.
- **Load:** write takes effect at the accept edge.
- **Reset values:**
  - `fetch_rsp_valid` = 0, `fetch_rsp_instr` = 0, `fetch_rsp_err` = 0.
  - `fetch_count` = 0, `load_count` = 0.
  - `fetch_req_ready` = 1 only if `load_valid` is low.
  - `load_ready` = 1.
- **Reset mid-operation:** a pending response is discarded immediately (valid drops asynchronously). Counters clear. Memory contents are retained.
- **Counters:** saturate rather than wrap. 16'hFFFF holds.

## Structure
- **Shared package `cpu_pkg`:**
  - `INSTR_W` = 32.
  - `NOP_INSTR` = 32'h0000_0000.
  - `IMEM_DEPTH` = 4096.
  - `typedef logic [31:0] word_t`.
  - Opcode constants, shared with the decoder.
- **Sub-module `imem_ram`:** one write port, one synchronous read port, `DEPTH` × 32, no reset. The response slot, range checks and counters stay in `imem_server`.

## Test plan
- **Basic fetch:** load 0→32'h0043_0820, 1→32'h8C22_0004. Fetch 0 then 1 back-to-back with rsp_ready=1 → responses on consecutive cycles, instr matches, err=0, fetch_count=2.
- **Backpressure:** fetch addr 1 with rsp_ready=0 for 3 cycles → rsp_valid held, instr stable at 32'h8C22_0004, fetch_req_ready=0. Raise ready → consumed, the next request is accepted in the same cycle.
- **Out of range:** fetch addr 4096 → instr=0, err=1, fetch_count increments. Load to addr 5000 → handshake completes, load_count unchanged.
- **Collision:** load_valid and fetch_req_valid together with the slot empty → load accepted, fetch_req_ready=0 that cycle. Fetch of the same address next cycle returns the new data.
- **Reset mid-operation:** deassert rst_n while rsp_valid=1 → rsp_valid=0 and counters=0 immediately. After release, fetch addr 0 returns the preload value.
- **Saturation:** force 65 540 fetches → fetch_count holds at 16'hFFFF.
